// File: rtl/edge_pe_task_ctrl_pkg.sv
// rtl/edge_pe_task_ctrl_pkg.sv - shared types and packet field layout for the edge PE task front end
`timescale 1ns/1ps
`ifndef PACKET_SIZE
`define PACKET_SIZE 20
`endif

package edge_pe_task_ctrl_pkg;

  // Dispatched packet width as seen on the dispatch bus
  localparam int DP_PKT_W = `PACKET_SIZE - 2;

  // Packet field layout: {base address, iter mask, edge count}
  localparam int CNT_LSB  = 0;
  localparam int CNT_W    = 7;
  localparam int ITER_LSB = 7;
  localparam int ITER_W   = 3;
  localparam int BASE_LSB = 10;

  typedef struct packed {
    logic                valid;
    logic [DP_PKT_W-1:0] packet;
  } DP_task2Edge_PE;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/edge_pe_task_ctrl_if.sv
// rtl/edge_pe_task_ctrl_if.sv - dispatch, bank-read and edge-stream signals of one edge PE front end
`timescale 1ns/1ps

interface edge_pe_task_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = edge_pe_task_ctrl_pkg::DP_PKT_W - 10
);

  edge_pe_task_ctrl_pkg::DP_task2Edge_PE DP_task2Edge_PE_in;
  logic              PE_IDLE;
  logic              bank_busy;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              edge_valid;
  logic [DATA_W-1:0] edge_data;
  logic [2:0]        edge_iter;
  logic              edge_last;
  logic              edge_ready;
  logic              task_done;
  logic              proto_err;

  // Environment side: dispatcher, bank and downstream consumer
  modport master (
    output DP_task2Edge_PE_in, rd_gnt, rd_valid, rd_data, edge_ready,
    input  PE_IDLE, bank_busy, rd_req, rd_addr, edge_valid, edge_data,
           edge_iter, edge_last, task_done, proto_err
  );

  // Controller side
  modport slave (
    input  DP_task2Edge_PE_in, rd_gnt, rd_valid, rd_data, edge_ready,
    output PE_IDLE, bank_busy, rd_req, rd_addr, edge_valid, edge_data,
           edge_iter, edge_last, task_done, proto_err
  );

endinterface

// File: rtl/edge_pe_task_ctrl.sv
// rtl/edge_pe_task_ctrl.sv - per-PE edge task fetch/stream controller; EDGE_PE_PERF_EN adds busy_cycles
`timescale 1ns/1ps

module edge_pe_task_ctrl
  import edge_pe_task_ctrl_pkg::*;
#(
  parameter int PKT_W  = `PACKET_SIZE - 2,
  parameter int DATA_W = 32,
  localparam int ADDR_W = PKT_W - 10
) (
  input logic               clk,
  input logic               reset,
  edge_pe_task_ctrl_if.slave bus
`ifdef EDGE_PE_PERF_EN
  ,
  output logic [15:0]       busy_cycles
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ITER_W-1:0] iter_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  index_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              pkt_valid;
  logic [CNT_W-1:0]  pkt_count;
  logic              is_last;

  assign pkt_valid = bus.DP_task2Edge_PE_in.valid;
  assign pkt_count = bus.DP_task2Edge_PE_in.packet[CNT_LSB +: CNT_W];
  assign is_last   = (index_q == count_q - 7'd1);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pkt_valid) state_nxt = (pkt_count == '0) ? DONE : REQ;
      REQ:  if (bus.rd_gnt) state_nxt = WAIT;
      WAIT: if (bus.rd_valid) state_nxt = SEND;
      SEND: if (bus.edge_ready) state_nxt = is_last ? DONE : REQ;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Task context, fetched word and sticky protocol error; packets outside IDLE are dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      base_q  <= '0;
      iter_q  <= '0;
      count_q <= '0;
      index_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && pkt_valid) begin
        base_q  <= bus.DP_task2Edge_PE_in.packet[PKT_W-1:BASE_LSB];
        iter_q  <= bus.DP_task2Edge_PE_in.packet[ITER_LSB +: ITER_W];
        count_q <= pkt_count;
        index_q <= '0;
      end
      if (state == SEND && bus.edge_ready && !is_last) index_q <= index_q + 7'd1;
      if (state == WAIT && bus.rd_valid) data_q <= bus.rd_data;
      if ((pkt_valid && state != IDLE) || (bus.rd_valid && state != WAIT)) err_q <= 1'b1;
    end
  end

  // Outputs decode straight from the registered state so the dispatcher sees them this cycle
  always_comb begin
    bus.PE_IDLE    = (state == IDLE);
    bus.bank_busy  = (state == REQ) || (state == WAIT) || (state == SEND);
    bus.rd_req     = (state == REQ);
    bus.rd_addr    = base_q + ADDR_W'(index_q);
    bus.edge_valid = (state == SEND);
    bus.edge_data  = data_q;
    bus.edge_iter  = iter_q;
    bus.edge_last  = (state == SEND) && is_last;
    bus.task_done  = (state == DONE);
    bus.proto_err  = err_q;
  end

`ifdef EDGE_PE_PERF_EN
  logic [15:0] busy_q;

  // Saturating count of non-idle cycles, kept across tasks
  always_ff @(posedge clk) begin
    if (!reset)                                 busy_q <= '0;
    else if (state != IDLE && busy_q != 16'hFFFF) busy_q <= busy_q + 16'd1;
  end

  assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_edge_pe_task_ctrl.sv
// tb/tb_edge_pe_task_ctrl.sv - directed self-checking bench for edge_pe_task_ctrl
`timescale 1ns/1ps

module tb_edge_pe_task_ctrl;

  logic clk;
  logic reset;
`ifdef EDGE_PE_PERF_EN
  logic [15:0] busy_cycles;
`endif

  edge_pe_task_ctrl_if bus ();

  edge_pe_task_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef EDGE_PE_PERF_EN
    ,
    .busy_cycles (busy_cycles)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state (written only by the responder process)
  logic [31:0] addr_q[$];
  logic [31:0] word_q[$];
  logic [31:0] last_q[$];
  logic [31:0] iter_q[$];
  int done_cnt = 0;
  int req_cnt  = 0;
  int ev_cnt   = 0;

  // Stall configuration (written only by the main process)
  int arm      = 0;
  int gnt_cfg  = 0;
  int rdy_cfg  = 0;
  logic inject_rdv = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {16'hC0DE, 8'h00, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] base, input logic [2:0] mask, input logic [6:0] cnt);
    @(posedge clk);
    #1;
    bus.DP_task2Edge_PE_in.valid  = 1'b1;
    bus.DP_task2Edge_PE_in.packet = {base, mask, cnt};
    @(posedge clk);
    #1;
    bus.DP_task2Edge_PE_in.valid  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int start;
    start = done_cnt;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done_cnt != start) break;
    end
    check(tag, 32'(done_cnt - start), 32'd1);
  endtask

  // Bank and downstream model plus monitor
  initial begin
    logic       g;
    logic [7:0] ga;
    int         seen;
    int         gcnt;
    int         rcnt;
    g = 1'b0; ga = '0; seen = 0; gcnt = 0; rcnt = 0;
    bus.rd_gnt     = 1'b0;
    bus.rd_valid   = 1'b0;
    bus.rd_data    = '0;
    bus.edge_ready = 1'b1;
    forever begin
      @(negedge clk);
      g  = bus.rd_req & bus.rd_gnt;
      ga = bus.rd_addr;
      if (g) addr_q.push_back(32'(bus.rd_addr));
      if (bus.edge_valid && bus.edge_ready) begin
        word_q.push_back(bus.edge_data);
        last_q.push_back(32'(bus.edge_last));
        iter_q.push_back(32'(bus.edge_iter));
      end
      if (bus.task_done)  done_cnt++;
      if (bus.rd_req)     req_cnt++;
      if (bus.edge_valid) ev_cnt++;
      @(posedge clk);
      #2;
      if (arm != seen) begin
        seen = arm; gcnt = 0; rcnt = 0;
      end
      bus.rd_valid = g | inject_rdv;
      bus.rd_data  = mem_word(ga);
      if (bus.rd_req && gcnt < gnt_cfg) begin
        bus.rd_gnt = 1'b0; gcnt++;
      end else begin
        bus.rd_gnt = bus.rd_req;
      end
      if (bus.edge_valid && rcnt < rdy_cfg) begin
        bus.edge_ready = 1'b0; rcnt++;
      end else begin
        bus.edge_ready = 1'b1;
      end
    end
  end

  // Directed sequence
  initial begin
    int a0, w0, d0, r0, e0;
    int found;

    reset = 1'b0;
    bus.DP_task2Edge_PE_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    tick();
    check("rst_idle",  32'(bus.PE_IDLE),    32'd1);
    check("rst_busy",  32'(bus.bank_busy),  32'd0);
    check("rst_req",   32'(bus.rd_req),     32'd0);
    check("rst_addr",  32'(bus.rd_addr),    32'd0);
    check("rst_ev",    32'(bus.edge_valid), 32'd0);
    check("rst_last",  32'(bus.edge_last),  32'd0);
    check("rst_data",  bus.edge_data,       32'd0);
    check("rst_iter",  32'(bus.edge_iter),  32'd0);
    check("rst_done",  32'(bus.task_done),  32'd0);
    check("rst_err",   32'(bus.proto_err),  32'd0);
`ifdef EDGE_PE_PERF_EN
    check("rst_perf",  32'(busy_cycles),    32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic 3-edge task, full-speed handshakes
    a0 = addr_q.size(); w0 = word_q.size(); d0 = done_cnt;
    send_pkt(8'h10, 3'b010, 7'd3);
    tick();
    check("a_req_t1",  32'(bus.rd_req),     32'd1);
    check("a_addr_t1", 32'(bus.rd_addr),    32'h10);
    check("a_busy_t1", 32'(bus.bank_busy),  32'd1);
    check("a_idle_t1", 32'(bus.PE_IDLE),    32'd0);
    repeat (8) tick();
    check("a_ev_t9",   32'(bus.edge_valid), 32'd1);
    check("a_last_t9", 32'(bus.edge_last),  32'd1);
    check("a_data_t9", bus.edge_data,       32'hC0DE0012);
    tick();
    check("a_done",    32'(bus.task_done),  32'd1);
    check("a_idle_dn", 32'(bus.PE_IDLE),    32'd0);
    check("a_busy_dn", 32'(bus.bank_busy),  32'd0);
    tick();
    check("a_idle_end", 32'(bus.PE_IDLE),   32'd1);
    check("a_done_end", 32'(bus.task_done), 32'd0);
    check("a_naddr",   32'(addr_q.size() - a0), 32'd3);
    check("a_nword",   32'(word_q.size() - w0), 32'd3);
    check("a_addr0",   addr_q[a0],   32'h10);
    check("a_addr1",   addr_q[a0+1], 32'h11);
    check("a_addr2",   addr_q[a0+2], 32'h12);
    check("a_word0",   word_q[w0],   32'hC0DE0010);
    check("a_word1",   word_q[w0+1], 32'hC0DE0011);
    check("a_word2",   word_q[w0+2], 32'hC0DE0012);
    check("a_last0",   last_q[w0],   32'd0);
    check("a_last1",   last_q[w0+1], 32'd0);
    check("a_last2",   last_q[w0+2], 32'd1);
    check("a_iter0",   iter_q[w0],   32'd2);
    check("a_iter2",   iter_q[w0+2], 32'd2);
    check("a_ndone",   32'(done_cnt - d0), 32'd1);
`ifdef EDGE_PE_PERF_EN
    check("a_perf",    32'(busy_cycles), 32'd10);
`endif

    // Zero-edge task
    r0 = req_cnt; e0 = ev_cnt; d0 = done_cnt;
    send_pkt(8'h55, 3'b000, 7'd0);
    tick();
    check("z_done_t1", 32'(bus.task_done), 32'd1);
    check("z_idle_t1", 32'(bus.PE_IDLE),   32'd0);
    check("z_req_t1",  32'(bus.rd_req),    32'd0);
    tick();
    check("z_idle_t2", 32'(bus.PE_IDLE),   32'd1);
    check("z_done_t2", 32'(bus.task_done), 32'd0);
    check("z_nreq",    32'(req_cnt - r0),  32'd0);
    check("z_nev",     32'(ev_cnt - e0),   32'd0);
    check("z_ndone",   32'(done_cnt - d0), 32'd1);

    // Address wrap
    a0 = addr_q.size(); w0 = word_q.size();
    send_pkt(8'hFE, 3'b001, 7'd3);
    wait_done("w_done", 40);
    tick();
    check("w_addr0", addr_q[a0],   32'hFE);
    check("w_addr1", addr_q[a0+1], 32'hFF);
    check("w_addr2", addr_q[a0+2], 32'h00);
    check("w_word2", word_q[w0+2], 32'hC0DE0000);
    check("w_last2", last_q[w0+2], 32'd1);

    // Grant stall then downstream stall
    arm++; gnt_cfg = 4; rdy_cfg = 5;
    a0 = addr_q.size(); w0 = word_q.size();
    send_pkt(8'h40, 3'b100, 7'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s_req",  32'(bus.rd_req),    32'd1);
      check("s_addr", 32'(bus.rd_addr),   32'h40);
      check("s_busy", 32'(bus.bank_busy), 32'd1);
    end
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.edge_valid) begin
        found = 1;
        break;
      end
    end
    check("s_ev_found", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) tick();
      check("s_ev_hold",   32'(bus.edge_valid), 32'd1);
      check("s_data_hold", bus.edge_data,       32'hC0DE0040);
      check("s_busy_hold", 32'(bus.bank_busy),  32'd1);
    end
    wait_done("s_done", 40);
    tick();
    check("s_nword", 32'(word_q.size() - w0), 32'd2);
    check("s_word0", word_q[w0],   32'hC0DE0040);
    check("s_word1", word_q[w0+1], 32'hC0DE0041);
    check("s_addr1", addr_q[a0+1], 32'h41);
    check("s_iter0", iter_q[w0],   32'd4);
    arm++; gnt_cfg = 0; rdy_cfg = 0;

    // Packet while busy is dropped and flags proto_err
    check("p_err_pre", 32'(bus.proto_err), 32'd0);
    a0 = addr_q.size(); w0 = word_q.size();
    send_pkt(8'h20, 3'b001, 7'd2);
    tick();
    tick();
    send_pkt(8'h77, 3'b111, 7'd1);
    tick();
    check("p_err_set", 32'(bus.proto_err), 32'd1);
    wait_done("p_done", 40);
    tick();
    check("p_naddr", 32'(addr_q.size() - a0), 32'd2);
    check("p_addr1", addr_q[a0+1], 32'h21);
    check("p_nword", 32'(word_q.size() - w0), 32'd2);
    check("p_word1", word_q[w0+1], 32'hC0DE0021);
    r0 = req_cnt;
    repeat (5) tick();
    check("p_idle",     32'(bus.PE_IDLE),   32'd1);
    check("p_noreq",    32'(req_cnt - r0),  32'd0);
    check("p_err_stay", 32'(bus.proto_err), 32'd1);

    // Reset in the middle of a task
    d0 = done_cnt;
    send_pkt(8'h30, 3'b111, 7'd3);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("m_idle", 32'(bus.PE_IDLE),    32'd1);
    check("m_busy", 32'(bus.bank_busy),  32'd0);
    check("m_req",  32'(bus.rd_req),     32'd0);
    check("m_addr", 32'(bus.rd_addr),    32'd0);
    check("m_ev",   32'(bus.edge_valid), 32'd0);
    check("m_last", 32'(bus.edge_last),  32'd0);
    check("m_data", bus.edge_data,       32'd0);
    check("m_iter", 32'(bus.edge_iter),  32'd0);
    check("m_done", 32'(bus.task_done),  32'd0);
    check("m_err",  32'(bus.proto_err),  32'd0);
`ifdef EDGE_PE_PERF_EN
    check("m_perf", 32'(busy_cycles),    32'd0);
`endif
    repeat (6) tick();
    check("m_ndone",    32'(done_cnt - d0), 32'd0);
    check("m_idle_end", 32'(bus.PE_IDLE),   32'd1);

    // Read data outside WAIT is ignored but flagged
    @(posedge clk);
    #1;
    inject_rdv = 1'b1;
    @(posedge clk);
    #1;
    inject_rdv = 1'b0;
    tick();
    check("v_err",  32'(bus.proto_err), 32'd1);
    check("v_idle", 32'(bus.PE_IDLE),   32'd1);
    check("v_ev",   32'(bus.edge_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
